memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage of the NeoCore 16x32 core, between the execute stage and writeback. It consumes both dual-issue slots from the EX/MEM register and serialises their loads and stores onto a single 16-bit data-memory port through a req/ack handshake. It stalls upstream while accesses are outstanding and splits misaligned halfword accesses into two byte beats. It registers writeback payloads and forwarding data for both slots.

## Interface
- No parameters. `ex_mem_t` and `mem_wb_t` come from `neocore_pkg`.
- `mem_wb_t` fields: valid, pc[31:0], rd_addr, rd2_addr, rd_we, rd2_we, wb_data[15:0], wb2_data[15:0], is_halt.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_0 / ex_mem_1  in  ex_mem_t  slot 0 / slot 1 from EX/MEM. Upstream holds these stable while mem_stall is high.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  halfword address; bit 0 is always 0.
- dmem_be  out  2  byte enables; [1] is the upper lane [15:8].
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data, valid in any cycle where dmem_ack is high.
- dmem_ack  in  1  beat complete.
- mem_stall  out  1  freeze PC, IF, ID and EX/MEM.
- mem_wb_0 / mem_wb_1  out  mem_wb_t  registered outputs to writeback.
- mem_fwd_data_0 / mem_fwd_data_1  out  16  equal to mem_wb_N.wb_data; feeds the execute-stage forwarding muxes.

## Operation
- A slot needs memory when valid && (mem_read || mem_write).
- mem_size encoding: 00 = byte, 01 = halfword, 10 and 11 = halfword.
- Memory is big-endian. The byte at an even address is on lane [15:8].
- Byte access at address A:
  - One beat, dmem_addr = {A[31:1],0}.
  - be = 10 when A[0] = 0, be = 01 when A[0] = 1.
  - Store data is mem_wdata[7:0] replicated on both lanes.
- Aligned halfword access (A[0] = 0): one beat, be = 11, data = mem_wdata.
- Misaligned halfword access (A[0] = 1): two beats, in order.
  - Beat 1: addr {A[31:1],0}, be = 01, carries the high byte.
  - Beat 2: addr {A[31:1],0} + 2, be = 10, carries the low byte.
- Load result:
  - Byte loads are zero-extended.
  - Misaligned halfword result = {beat1 lane [7:0], beat2 lane [15:8]}.
- Slot 0 is always accessed before slot 1. Store/load ordering is preserved even when both slots hit the same address.
- wb_data is the load result for loads, otherwise alu_result[15:0]. wb2_data = alu_result[31:16].
- All other mem_wb fields are copied from ex_mem unchanged.
- An invalid slot produces mem_wb.valid = 0 and its write enables are forced to 0.
- FSM states: IDLE, ACC0, ACC1, DONE.
  - IDLE → ACC0 if slot 0 needs memory.
  - IDLE → ACC1 if only slot 1 needs memory.
  - IDLE stays IDLE and captures outputs if neither slot needs memory.
  - ACC0 → ACC1 on slot 0's final ack when slot 1 needs memory, otherwise → DONE.
  - ACC1 → DONE on its final ack.
  - DONE → IDLE, capturing mem_wb at that edge.
- A 1-bit beat counter in each ACC state selects beat 1 or beat 2.

## Timing
- mem_stall = (IDLE && either slot needs memory) || ACC0 || ACC1. It is combinational and low in DONE.
- dmem_req is high in ACC0 and ACC1 only.
- addr, be, we and wdata stay stable until dmem_ack. A beat completes at the edge where req && ack are both high.
- Back-to-back beats: req stays high, and the next beat's address appears in the cycle after the ack.
- Ack in the first req cycle (zero wait) is legal.
- Latency without memory ops: mem_wb is valid one cycle after the inputs, with no stall.
- Latency with memory ops: 1 + Σbeats×(1 + wait) + 1 cycles from input to mem_wb.
  - Example: one zero-wait aligned load takes 3 cycles and stalls for 2.
- mem_wb holds its value while stalled. The valid fields are cleared in the cycle after any capture where the inputs were invalid.
- Reset values:
  - state = IDLE; dmem_req, dmem_we and dmem_be = 0; dmem_addr and dmem_wdata = 0.
  - mem_wb_0/1 all zeros (valid = 0); mem_fwd_data = 0.
- Reset mid-access abandons the beat immediately, dropping req at that edge, and discards partial load data.
- dmem_ack while req is low is ignored.

## Test plan
- Slot 0 ADD (alu_result 0x0000_1234, rd_we = 1), slot 1 invalid:
  - mem_stall stays 0.
  - Next cycle mem_wb_0.wb_data = 0x1234, mem_wb_1.valid = 0.
- Slot 0 halfword load from 0x100, memory returns 0xBEEF with zero wait:
  - mem_stall is high for 2 cycles.
  - Single beat with be = 11.
  - wb_data = 0xBEEF in the cycle after DONE.
- Slot 0 misaligned halfword store of 0xA1B2 to 0x201, ack delayed 2 cycles per beat:
  - Beat 1: addr 0x200, be = 01, wdata low lane 0xA1.
  - Beat 2: addr 0x202, be = 10, wdata high lane 0xB2.
- Slot 0 byte store of 0x7F to 0x300, slot 1 byte load from 0x300:
  - The store beat precedes the load.
  - Load wb_data = 0x007F.
- Slot 0 byte load from 0x401 with memory returning 0x1299: wb_data = 0x0099.
- Assert rst during a wait state of ACC1:
  - dmem_req = 0 after the edge.
  - All outputs are at reset values and state is IDLE.
  - A subsequent ALU pair completes normally.

Source files
------------

// File: rtl/neocore_pkg.sv
// Shared NeoCore pipeline payload types and widths.
package neocore_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 16;
    localparam int unsigned RLEN = 4;

    // EX/MEM register payload for one issue slot; alu_result doubles as the memory address.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RLEN-1:0] rd_addr;
        logic [RLEN-1:0] rd2_addr;
        logic            rd_we;
        logic            rd2_we;
        logic [XLEN-1:0] alu_result;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic [DLEN-1:0] mem_wdata;
        logic            is_halt;
    } ex_mem_t;

    // MEM/WB register payload for one issue slot.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RLEN-1:0] rd_addr;
        logic [RLEN-1:0] rd2_addr;
        logic            rd_we;
        logic            rd2_we;
        logic [DLEN-1:0] wb_data;
        logic [DLEN-1:0] wb2_data;
        logic            is_halt;
    } mem_wb_t;

    // One data-memory beat as driven on the dmem port.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [1:0]      be;
        logic            we;
        logic [DLEN-1:0] wdata;
    } dmem_beat_t;

endpackage

// File: rtl/memory_stage.sv
// NeoCore MEM stage: serialises both slots' loads/stores onto one 16-bit
// big-endian data port and registers the writeback payloads.
module memory_stage
    import neocore_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  ex_mem_t         ex_mem_0,
    input  ex_mem_t         ex_mem_1,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [1:0]      dmem_be,
    output logic [DLEN-1:0] dmem_wdata,
    input  logic [DLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            mem_stall,
    output mem_wb_t         mem_wb_0,
    output mem_wb_t         mem_wb_1,
    output logic [DLEN-1:0] mem_fwd_data_0,
    output logic [DLEN-1:0] mem_fwd_data_1
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ACC0 = 2'b01;
    localparam logic [1:0] S_ACC1 = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic [1:0]      state, state_nxt;
    logic            beat, beat_nxt;
    logic [7:0]      hi_byte, hi_byte_nxt;
    logic [DLEN-1:0] ld0, ld0_nxt, ld1, ld1_nxt;
    logic            req_nxt;
    dmem_beat_t      issue_nxt;
    mem_wb_t         wb0_nxt, wb1_nxt;
    logic            need0, need1;
    ex_mem_t         cur_slot;
    logic            cur_last;

    // Address, lanes and data for beat b of a slot's access.
    function automatic dmem_beat_t plan_beat(input ex_mem_t s, input logic b);
        dmem_beat_t      p;
        logic [XLEN-1:0] base;
        base    = {s.alu_result[XLEN-1:1], 1'b0};
        p.addr  = base;
        p.we    = s.mem_write;
        p.be    = 2'b11;
        p.wdata = s.mem_wdata;
        if (s.mem_size == 2'b00) begin
            p.be    = s.alu_result[0] ? 2'b01 : 2'b10;
            p.wdata = {2{s.mem_wdata[7:0]}};
        end else if (s.alu_result[0]) begin
            if (!b) begin
                p.be    = 2'b01;
                p.wdata = {2{s.mem_wdata[15:8]}};
            end else begin
                p.addr  = base + XLEN'(2);
                p.be    = 2'b10;
                p.wdata = {2{s.mem_wdata[7:0]}};
            end
        end
        return p;
    endfunction

    // Only the first beat of a misaligned halfword is non-final.
    function automatic logic beat_is_last(input ex_mem_t s, input logic b);
        return !((s.mem_size != 2'b00) && s.alu_result[0] && !b);
    endfunction

    // Assemble the load result on the final beat (byte loads zero-extended).
    function automatic logic [DLEN-1:0] load_value(input ex_mem_t s, input logic [7:0] hb,
                                                    input logic [DLEN-1:0] rd);
        if (s.mem_size == 2'b00)
            return s.alu_result[0] ? {8'h00, rd[7:0]} : {8'h00, rd[15:8]};
        else if (s.alu_result[0])
            return {hb, rd[15:8]};
        else
            return rd;
    endfunction

    // Writeback payload; invalid slots never write the register file.
    function automatic mem_wb_t build_wb(input ex_mem_t e, input logic [DLEN-1:0] ld);
        mem_wb_t w;
        w.valid    = e.valid;
        w.pc       = e.pc;
        w.rd_addr  = e.rd_addr;
        w.rd2_addr = e.rd2_addr;
        w.rd_we    = e.valid && e.rd_we;
        w.rd2_we   = e.valid && e.rd2_we;
        w.wb_data  = (e.valid && e.mem_read) ? ld : e.alu_result[DLEN-1:0];
        w.wb2_data = e.alu_result[XLEN-1:DLEN];
        w.is_halt  = e.is_halt;
        return w;
    endfunction

    // Slot memory demand and upstream freeze.
    always_comb begin
        need0     = ex_mem_0.valid && (ex_mem_0.mem_read || ex_mem_0.mem_write);
        need1     = ex_mem_1.valid && (ex_mem_1.mem_read || ex_mem_1.mem_write);
        mem_stall = ((state == S_IDLE) && (need0 || need1)) ||
                    (state == S_ACC0) || (state == S_ACC1);
        cur_slot  = (state == S_ACC1) ? ex_mem_1 : ex_mem_0;
        cur_last  = beat_is_last(cur_slot, beat);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        hi_byte_nxt = hi_byte;
        ld0_nxt     = ld0;
        ld1_nxt     = ld1;
        req_nxt     = dmem_req;
        issue_nxt   = {dmem_addr, dmem_be, dmem_we, dmem_wdata};
        wb0_nxt     = mem_wb_0;
        wb1_nxt     = mem_wb_1;
        case (state)
            S_IDLE: begin
                if (need0) begin
                    state_nxt = S_ACC0;
                    beat_nxt  = 1'b0;
                    req_nxt   = 1'b1;
                    issue_nxt = plan_beat(ex_mem_0, 1'b0);
                end else if (need1) begin
                    state_nxt = S_ACC1;
                    beat_nxt  = 1'b0;
                    req_nxt   = 1'b1;
                    issue_nxt = plan_beat(ex_mem_1, 1'b0);
                end else begin
                    wb0_nxt = build_wb(ex_mem_0, ld0);
                    wb1_nxt = build_wb(ex_mem_1, ld1);
                end
            end
            S_ACC0, S_ACC1: begin
                if (dmem_req && dmem_ack) begin
                    if (!cur_last) begin
                        hi_byte_nxt = dmem_rdata[7:0];
                        beat_nxt    = 1'b1;
                        issue_nxt   = plan_beat(cur_slot, 1'b1);
                    end else begin
                        if (state == S_ACC0)
                            ld0_nxt = load_value(cur_slot, hi_byte, dmem_rdata);
                        else
                            ld1_nxt = load_value(cur_slot, hi_byte, dmem_rdata);
                        if ((state == S_ACC0) && need1) begin
                            state_nxt = S_ACC1;
                            beat_nxt  = 1'b0;
                            issue_nxt = plan_beat(ex_mem_1, 1'b0);
                        end else begin
                            state_nxt    = S_DONE;
                            req_nxt      = 1'b0;
                            issue_nxt.we = 1'b0;
                            issue_nxt.be = 2'b00;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                wb0_nxt   = build_wb(ex_mem_0, ld0);
                wb1_nxt   = build_wb(ex_mem_1, ld1);
            end
        endcase
    end

    // State and output registers; reset abandons any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= 1'b0;
            hi_byte    <= '0;
            ld0        <= '0;
            ld1        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_wb_0   <= '0;
            mem_wb_1   <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            hi_byte    <= hi_byte_nxt;
            ld0        <= ld0_nxt;
            ld1        <= ld1_nxt;
            dmem_req   <= req_nxt;
            dmem_we    <= issue_nxt.we;
            dmem_be    <= issue_nxt.be;
            dmem_addr  <= issue_nxt.addr;
            dmem_wdata <= issue_nxt.wdata;
            mem_wb_0   <= wb0_nxt;
            mem_wb_1   <= wb1_nxt;
        end
    end

    assign mem_fwd_data_0 = mem_wb_0.wb_data;
    assign mem_fwd_data_1 = mem_wb_1.wb_data;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded bench for memory_stage with a wait-state programmable memory.
`timescale 1ns/1ps
module tb_memory_stage;
    import neocore_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ex_mem_t     ex_mem_0, ex_mem_1;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = 16'hDEAD;
    logic        dmem_ack = 1'b0;
    logic        mem_stall;
    mem_wb_t     mem_wb_0, mem_wb_1;
    logic [15:0] mem_fwd_data_0, mem_fwd_data_1;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .ex_mem_0(ex_mem_0), .ex_mem_1(ex_mem_1),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_stall(mem_stall), .mem_wb_0(mem_wb_0),
        .mem_wb_1(mem_wb_1), .mem_fwd_data_0(mem_fwd_data_0),
        .mem_fwd_data_1(mem_fwd_data_1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] wmask;
    } beat_t;

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        int          stalls;
    } wb_exp_t;

    beat_t       exp_beats[$];
    beat_t       obs_beats[$];
    wb_exp_t     exp_wb[$];
    logic [7:0]  mem [logic [31:0]];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          passed = 0;
    int          total = 0;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Big-endian memory: acks after ack_wait idle cycles, logs each completed beat.
    always @(negedge clk) begin
        dmem_ack   = 1'b0;
        dmem_rdata = 16'hDEAD;
        if (dmem_req === 1'b1 && rst === 1'b0) begin
            if (wait_cnt >= ack_wait) begin
                beat_t o;
                o.addr  = dmem_addr;
                o.be    = dmem_be;
                o.we    = dmem_we;
                o.wdata = dmem_wdata;
                o.wmask = 16'hFFFF;
                obs_beats.push_back(o);
                dmem_rdata = {rd_byte(dmem_addr), rd_byte(dmem_addr + 32'd1)};
                if (dmem_we) begin
                    if (dmem_be[1]) mem[dmem_addr] = dmem_wdata[15:8];
                    if (dmem_be[0]) mem[dmem_addr + 32'd1] = dmem_wdata[7:0];
                end
                dmem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic ex_mem_t mk(input logic v, input logic [31:0] alu, input logic mr,
                                   input logic mw, input logic [1:0] sz, input logic [15:0] wd);
        ex_mem_t e;
        e            = '0;
        e.valid      = v;
        e.pc         = 32'h0000_1000;
        e.rd_addr    = 4'd3;
        e.rd2_addr   = 4'd4;
        e.rd_we      = !mw;
        e.alu_result = alu;
        e.mem_read   = mr;
        e.mem_write  = mw;
        e.mem_size   = sz;
        e.mem_wdata  = wd;
        return e;
    endfunction

    function automatic beat_t mkb(input logic [31:0] a, input logic [1:0] be, input logic we,
                                  input logic [15:0] wd, input logic [15:0] wm);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.wmask = wm;
        return b;
    endfunction

    function automatic wb_exp_t mkw(input logic v0, input logic [15:0] d0, input logic v1,
                                    input logic [15:0] d1, input int st);
        wb_exp_t w;
        w.v0 = v0; w.d0 = d0; w.v1 = v1; w.d1 = d1; w.stalls = st;
        return w;
    endfunction

    // Present a slot pair, count stall cycles, return once mem_wb has been captured.
    task automatic run_txn(input ex_mem_t a, input ex_mem_t b, output int stalls, output bit to);
        bit s;
        @(negedge clk);
        ex_mem_0 = a;
        ex_mem_1 = b;
        stalls   = 0;
        to       = 1'b1;
        #1;
        for (int c = 0; c < 200; c++) begin
            s = mem_stall;
            if (s) stalls++;
            @(posedge clk);
            #1;
            if (!s) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
        ex_mem_0 = '0;
        ex_mem_1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_mem_0 = '0;
        ex_mem_1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 2'b00)
            $display("FAIL reset_ctl: req=%b we=%b be=%b want 0 0 00", dmem_req, dmem_we, dmem_be);
        else passed++;
        total++;
        if (dmem_addr !== 32'h0 || dmem_wdata !== 16'h0)
            $display("FAIL reset_addr: addr=%h wdata=%h want 0 0", dmem_addr, dmem_wdata);
        else passed++;
        total++;
        if (mem_wb_0 !== '0 || mem_wb_1 !== '0)
            $display("FAIL reset_wb: wb0=%h wb1=%h want 0", mem_wb_0, mem_wb_1);
        else passed++;
        total++;
        if (mem_fwd_data_0 !== 16'h0 || mem_fwd_data_1 !== 16'h0 || mem_stall !== 1'b0)
            $display("FAIL reset_fwd: fwd0=%h fwd1=%h stall=%b want 0", mem_fwd_data_0, mem_fwd_data_1, mem_stall);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        int st; bit to; wb_exp_t e;
        exp_wb.push_back(mkw(1'b1, 16'h1234, 1'b0, 16'h0, 0));
        run_txn(mk(1'b1, 32'h0000_1234, 1'b0, 1'b0, 2'b00, 16'h0), '0, st, to);
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL alu_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0 || mem_fwd_data_0 !== e.d0 || mem_wb_0.rd_we !== 1'b1)
            $display("FAIL alu_wb0: v=%b data=%h fwd=%h we=%b want 1 %h", mem_wb_0.valid, mem_wb_0.wb_data, mem_fwd_data_0, mem_wb_0.rd_we, e.d0);
        else passed++;
        total++;
        if (mem_wb_1.valid !== e.v1 || mem_wb_1.rd_we !== 1'b0)
            $display("FAIL alu_wb1: v=%b we=%b want 0 0", mem_wb_1.valid, mem_wb_1.rd_we);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (mem_wb_0.valid !== 1'b0) $display("FAIL alu_clear: valid=%b want 0", mem_wb_0.valid);
        else passed++;
    endtask

    task automatic test_aligned_load();
        int st; bit to; wb_exp_t e; beat_t eb, ob;
        mem[32'h100] = 8'hBE;
        mem[32'h101] = 8'hEF;
        exp_beats.push_back(mkb(32'h100, 2'b11, 1'b0, 16'h0, 16'h0));
        exp_wb.push_back(mkw(1'b1, 16'hBEEF, 1'b0, 16'h0, 2));
        run_txn(mk(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 16'h0), '0, st, to);
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL aload_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (obs_beats.size() !== exp_beats.size()) $display("FAIL aload_nbeats: got %0d want %0d", obs_beats.size(), exp_beats.size());
        else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            eb = exp_beats.pop_front(); ob = obs_beats.pop_front(); total++;
            if (ob.addr !== eb.addr || ob.be !== eb.be || ob.we !== eb.we || ((ob.wdata ^ eb.wdata) & eb.wmask) !== 16'h0)
                $display("FAIL aload_beat: addr=%h be=%b we=%b wd=%h want %h %b %b %h", ob.addr, ob.be, ob.we, ob.wdata, eb.addr, eb.be, eb.we, eb.wdata);
            else passed++;
        end
        exp_beats.delete(); obs_beats.delete();
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0 || mem_wb_1.valid !== e.v1)
            $display("FAIL aload_wb: v0=%b d0=%h v1=%b want 1 %h 0", mem_wb_0.valid, mem_wb_0.wb_data, mem_wb_1.valid, e.d0);
        else passed++;
    endtask

    task automatic test_misaligned_store();
        int st; bit to; wb_exp_t e; beat_t eb, ob;
        ack_wait = 2;
        mem[32'h200] = 8'h55;
        mem[32'h203] = 8'h66;
        exp_beats.push_back(mkb(32'h200, 2'b01, 1'b1, 16'h00A1, 16'h00FF));
        exp_beats.push_back(mkb(32'h202, 2'b10, 1'b1, 16'hB200, 16'hFF00));
        exp_wb.push_back(mkw(1'b1, 16'h0201, 1'b0, 16'h0, 7));
        run_txn(mk(1'b1, 32'h201, 1'b0, 1'b1, 2'b01, 16'hA1B2), '0, st, to);
        ack_wait = 0;
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL mstore_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (obs_beats.size() !== exp_beats.size()) $display("FAIL mstore_nbeats: got %0d want %0d", obs_beats.size(), exp_beats.size());
        else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            eb = exp_beats.pop_front(); ob = obs_beats.pop_front(); total++;
            if (ob.addr !== eb.addr || ob.be !== eb.be || ob.we !== eb.we || ((ob.wdata ^ eb.wdata) & eb.wmask) !== 16'h0)
                $display("FAIL mstore_beat: addr=%h be=%b we=%b wd=%h want %h %b %b %h", ob.addr, ob.be, ob.we, ob.wdata, eb.addr, eb.be, eb.we, eb.wdata);
            else passed++;
        end
        exp_beats.delete(); obs_beats.delete();
        total++;
        if (rd_byte(32'h200) !== 8'h55 || rd_byte(32'h201) !== 8'hA1 || rd_byte(32'h202) !== 8'hB2 || rd_byte(32'h203) !== 8'h66)
            $display("FAIL mstore_mem: %h %h %h %h want 55 a1 b2 66", rd_byte(32'h200), rd_byte(32'h201), rd_byte(32'h202), rd_byte(32'h203));
        else passed++;
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0 || mem_wb_0.rd_we !== 1'b0)
            $display("FAIL mstore_wb: v0=%b d0=%h we=%b want 1 %h 0", mem_wb_0.valid, mem_wb_0.wb_data, mem_wb_0.rd_we, e.d0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int st; bit to; wb_exp_t e; beat_t eb, ob;
        mem[32'h300] = 8'h11;
        exp_beats.push_back(mkb(32'h300, 2'b10, 1'b1, 16'h7F7F, 16'hFFFF));
        exp_beats.push_back(mkb(32'h300, 2'b10, 1'b0, 16'h0, 16'h0));
        exp_wb.push_back(mkw(1'b1, 16'h0300, 1'b1, 16'h007F, 3));
        run_txn(mk(1'b1, 32'h300, 1'b0, 1'b1, 2'b00, 16'h007F),
                mk(1'b1, 32'h300, 1'b1, 1'b0, 2'b00, 16'h0), st, to);
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL b2b_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (obs_beats.size() !== exp_beats.size()) $display("FAIL b2b_nbeats: got %0d want %0d", obs_beats.size(), exp_beats.size());
        else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            eb = exp_beats.pop_front(); ob = obs_beats.pop_front(); total++;
            if (ob.addr !== eb.addr || ob.be !== eb.be || ob.we !== eb.we || ((ob.wdata ^ eb.wdata) & eb.wmask) !== 16'h0)
                $display("FAIL b2b_beat: addr=%h be=%b we=%b wd=%h want %h %b %b %h", ob.addr, ob.be, ob.we, ob.wdata, eb.addr, eb.be, eb.we, eb.wdata);
            else passed++;
        end
        exp_beats.delete(); obs_beats.delete();
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0 || mem_wb_1.valid !== e.v1 ||
            mem_wb_1.wb_data !== e.d1 || mem_fwd_data_1 !== e.d1)
            $display("FAIL b2b_wb: v0=%b d0=%h v1=%b d1=%h fwd1=%h want 1 %h 1 %h", mem_wb_0.valid, mem_wb_0.wb_data, mem_wb_1.valid, mem_wb_1.wb_data, mem_fwd_data_1, e.d0, e.d1);
        else passed++;
    endtask

    task automatic test_byte_load();
        int st; bit to; wb_exp_t e; beat_t eb, ob;
        mem[32'h400] = 8'h12;
        mem[32'h401] = 8'h99;
        exp_beats.push_back(mkb(32'h400, 2'b01, 1'b0, 16'h0, 16'h0));
        exp_wb.push_back(mkw(1'b1, 16'h0099, 1'b0, 16'h0, 2));
        run_txn(mk(1'b1, 32'h401, 1'b1, 1'b0, 2'b00, 16'h0), '0, st, to);
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL bload_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (obs_beats.size() !== exp_beats.size()) $display("FAIL bload_nbeats: got %0d want %0d", obs_beats.size(), exp_beats.size());
        else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            eb = exp_beats.pop_front(); ob = obs_beats.pop_front(); total++;
            if (ob.addr !== eb.addr || ob.be !== eb.be || ob.we !== eb.we)
                $display("FAIL bload_beat: addr=%h be=%b we=%b want %h %b %b", ob.addr, ob.be, ob.we, eb.addr, eb.be, eb.we);
            else passed++;
        end
        exp_beats.delete(); obs_beats.delete();
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0)
            $display("FAIL bload_wb: v0=%b d0=%h want 1 %h", mem_wb_0.valid, mem_wb_0.wb_data, e.d0);
        else passed++;
    endtask

    task automatic test_misaligned_load();
        int st; bit to; wb_exp_t e; beat_t eb, ob;
        ack_wait = 1;
        mem[32'h500] = 8'h11; mem[32'h501] = 8'h22;
        mem[32'h502] = 8'h33; mem[32'h503] = 8'h44;
        exp_beats.push_back(mkb(32'h500, 2'b01, 1'b0, 16'h0, 16'h0));
        exp_beats.push_back(mkb(32'h502, 2'b10, 1'b0, 16'h0, 16'h0));
        exp_wb.push_back(mkw(1'b1, 16'h0042, 1'b1, 16'h2233, 5));
        run_txn(mk(1'b1, 32'h0000_0042, 1'b0, 1'b0, 2'b00, 16'h0),
                mk(1'b1, 32'h501, 1'b1, 1'b0, 2'b10, 16'h0), st, to);
        ack_wait = 0;
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL mload_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (obs_beats.size() !== exp_beats.size()) $display("FAIL mload_nbeats: got %0d want %0d", obs_beats.size(), exp_beats.size());
        else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            eb = exp_beats.pop_front(); ob = obs_beats.pop_front(); total++;
            if (ob.addr !== eb.addr || ob.be !== eb.be || ob.we !== eb.we)
                $display("FAIL mload_beat: addr=%h be=%b we=%b want %h %b %b", ob.addr, ob.be, ob.we, eb.addr, eb.be, eb.we);
            else passed++;
        end
        exp_beats.delete(); obs_beats.delete();
        total++;
        if (mem_wb_0.wb_data !== e.d0 || mem_wb_1.valid !== e.v1 || mem_wb_1.wb_data !== e.d1)
            $display("FAIL mload_wb: d0=%h v1=%b d1=%h want %h 1 %h", mem_wb_0.wb_data, mem_wb_1.valid, mem_wb_1.wb_data, e.d0, e.d1);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        int st; bit to; wb_exp_t e;
        ack_wait = 10;
        @(negedge clk);
        ex_mem_0 = mk(1'b1, 32'h0000_0010, 1'b0, 1'b0, 2'b00, 16'h0);
        ex_mem_1 = mk(1'b1, 32'h600, 1'b1, 1'b0, 2'b01, 16'h0);
        repeat (3) @(negedge clk);
        total++;
        if (dmem_req !== 1'b1 || dut.state !== 2'b10)
            $display("FAIL rmid_pre: req=%b state=%b want 1 10", dmem_req, dut.state);
        else passed++;
        rst = 1'b1;
        ex_mem_0 = '0;
        ex_mem_1 = '0;
        @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b0 || dut.state !== 2'b00 || dmem_be !== 2'b00 || dmem_addr !== 32'h0 || dmem_we !== 1'b0)
            $display("FAIL rmid_req: req=%b state=%b be=%b addr=%h we=%b want 0 00 00 0 0", dmem_req, dut.state, dmem_be, dmem_addr, dmem_we);
        else passed++;
        total++;
        if (mem_wb_0 !== '0 || mem_wb_1 !== '0 || mem_stall !== 1'b0 || obs_beats.size() !== 0)
            $display("FAIL rmid_out: wb0=%h wb1=%h stall=%b beats=%0d want 0", mem_wb_0, mem_wb_1, mem_stall, obs_beats.size());
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        ack_wait = 0;
        exp_beats.delete();
        obs_beats.delete();
        exp_wb.push_back(mkw(1'b1, 16'h5555, 1'b1, 16'h0042, 0));
        run_txn(mk(1'b1, 32'h0000_5555, 1'b0, 1'b0, 2'b00, 16'h0),
                mk(1'b1, 32'hABCD_0042, 1'b0, 1'b0, 2'b00, 16'h0), st, to);
        e = exp_wb.pop_front();
        total++;
        if (to || st !== e.stalls) $display("FAIL rmid_alu_stall: stalls=%0d timeout=%0b want %0d", st, to, e.stalls);
        else passed++;
        total++;
        if (mem_wb_0.valid !== e.v0 || mem_wb_0.wb_data !== e.d0 || mem_wb_1.valid !== e.v1 ||
            mem_wb_1.wb_data !== e.d1 || mem_wb_1.wb2_data !== 16'hABCD)
            $display("FAIL rmid_alu_wb: v0=%b d0=%h v1=%b d1=%h d1hi=%h want 1 %h 1 %h abcd", mem_wb_0.valid, mem_wb_0.wb_data, mem_wb_1.valid, mem_wb_1.wb_data, mem_wb_1.wb2_data, e.d0, e.d1);
        else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        ex_mem_0 = '0;
        ex_mem_1 = '0;
        test_reset();
        test_alu();
        test_aligned_load();
        test_misaligned_store();
        test_back_to_back();
        test_byte_load();
        test_misaligned_load();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
